// File: rtl/dma_pcie_axis_rq_arb.sv
// Packet-aware NUM_CH:1 round-robin arbiter for PCIe RQ AXI-Stream, registered through a 2-entry skid buffer.
// Optional macro DMA_RQ_ARB_PRIO_CH0_EN gives channel 0 strict priority at packet boundaries.
module dma_pcie_axis_rq_arb #(
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 137,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_CH*USER_WIDTH-1:0]   s_tuser,
  input  logic [NUM_CH*DATA_WIDTH/32-1:0] s_tkeep,
  input  logic [NUM_CH-1:0]              s_tlast,
  input  logic [NUM_CH-1:0]              s_tvalid,
  output logic [NUM_CH-1:0]              s_tready,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic [USER_WIDTH-1:0]          m_tuser,
  output logic [DATA_WIDTH/32-1:0]       m_tkeep,
  output logic                           m_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [CH_W-1:0]                m_tch
);
  localparam int KW = DATA_WIDTH / 32;
  localparam int BW = DATA_WIDTH + USER_WIDTH + KW + 1 + CH_W;

  logic            lock, found, acc, rdy, skid_vld;
  logic [CH_W-1:0] gnt, last_gnt, sel, cur, c;
  logic [BW-1:0]   beat, main_q, skid_q;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    c     = '0;
`ifdef DMA_RQ_ARB_PRIO_CH0_EN
    if (s_tvalid[0]) begin
      sel   = '0;
      found = 1'b1;
    end else begin
      for (int i = 1; i <= NUM_CH; i++) begin
        c = CH_W'((int'(last_gnt) + i) % NUM_CH);
        if (!found && s_tvalid[c]) begin
          sel   = c;
          found = 1'b1;
        end
      end
    end
`else
    for (int i = 1; i <= NUM_CH; i++) begin
      c = CH_W'((int'(last_gnt) + i) % NUM_CH);
      if (!found && s_tvalid[c]) begin
        sel   = c;
        found = 1'b1;
      end
    end
`endif
  end

  assign cur  = lock ? gnt : sel;
  assign acc  = rdy && (lock ? s_tvalid[gnt] : found);
  assign beat = {s_tdata[cur*DATA_WIDTH +: DATA_WIDTH], s_tuser[cur*USER_WIDTH +: USER_WIDTH],
                 s_tkeep[cur*KW +: KW], s_tlast[cur], cur};

  // While locked the granted source sees ready even across its own valid gaps.
  always_comb begin
    s_tready = '0;
    if (rdy && (lock || found)) s_tready[cur] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock     <= 1'b0;
      gnt      <= '0;
      last_gnt <= CH_W'(NUM_CH - 1);
    end else if (acc) begin
      if (!lock) begin
`ifdef DMA_RQ_ARB_PRIO_CH0_EN
        if (sel != '0) last_gnt <= sel;
`else
        last_gnt <= sel;
`endif
        if (!s_tlast[cur]) begin
          lock <= 1'b1;
          gnt  <= sel;
        end
      end else if (s_tlast[cur]) begin
        lock <= 1'b0;
      end
    end
  end

  // rdy is the registered "skid empty" flag, so m_tready never reaches s_tready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      m_tvalid <= 1'b0;
      skid_vld <= 1'b0;
      rdy      <= 1'b0;
    end else begin
      if (!m_tvalid || m_tready) begin
        rdy <= 1'b1;
        if (skid_vld) begin
          main_q   <= skid_q;
          m_tvalid <= 1'b1;
          skid_vld <= 1'b0;
        end else if (acc) begin
          main_q   <= beat;
          m_tvalid <= 1'b1;
        end else begin
          m_tvalid <= 1'b0;
        end
      end else begin
        rdy <= !(skid_vld || acc);
        if (acc) begin
          skid_q   <= beat;
          skid_vld <= 1'b1;
        end
      end
    end
  end

  assign {m_tdata, m_tuser, m_tkeep, m_tlast, m_tch} = main_q;
endmodule
